// File: rtl/axis_pkt_gen.sv
// AXI-stream packet source: emits cfg_count frames of cfg_len bytes with a
// seeded incrementing byte pattern, tkeep on the tail beat and optional tuser marking.
module axis_pkt_gen #(
   parameter int DATA_WIDTH  = 32,
   parameter int KEEP_ENABLE = 1,
   parameter int KEEP_WIDTH  = DATA_WIDTH/8,
   parameter int LEN_WIDTH   = 16,
   parameter int CNT_WIDTH   = 16,
   parameter int GAP_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_start,
   input  logic                  cfg_abort,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic [CNT_WIDTH-1:0]  cfg_count,
   input  logic [GAP_WIDTH-1:0]  cfg_gap,
   input  logic [7:0]            cfg_seed,
   input  logic                  cfg_err_inj,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  pkt_sent,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser
);
   localparam int LW1 = LEN_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;
   state_t state_q, state_d;

   logic [LEN_WIDTH-1:0]  len_q, off_q;
   logic [CNT_WIDTH-1:0]  cnt_q, sent_q;
   logic [GAP_WIDTH-1:0]  gap_q, gcnt_q;
   logic [7:0]            seed_q;
   logic                  err_q, abort_q;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic [KEEP_WIDTH-1:0] tkeep_q;
   logic                  tvalid_q, tlast_q, tuser_q;

   logic                  hs, last_pkt, load;
   logic [LEN_WIDTH-1:0]  g_len, g_off;
   logic [CNT_WIDTH-1:0]  g_pkt, g_cnt;
   logic [7:0]            g_seed;
   logic                  g_err, g_last, g_user;
   logic [DATA_WIDTH-1:0] g_data;
   logic [KEEP_WIDTH-1:0] g_keep;

   assign hs       = tvalid_q & m_axis_tready;
   // an abort seen on the final handshake simply ends the run like any final packet
   assign last_pkt = (sent_q + CNT_WIDTH'(1) == cnt_q) | abort_q | cfg_abort;

   // Coordinates of the beat to present next: from cfg on start, else from latched config.
   always_comb begin
      g_len  = len_q;
      g_seed = seed_q;
      g_cnt  = cnt_q;
      g_err  = err_q;
      g_pkt  = sent_q;
      g_off  = '0;
      if (state_q == S_IDLE) begin
         g_len  = cfg_len;
         g_seed = cfg_seed;
         g_cnt  = cfg_count;
         g_err  = cfg_err_inj;
         g_pkt  = '0;
      end else if (hs && tlast_q) begin
         g_pkt  = sent_q + CNT_WIDTH'(1);
      end else if (hs) begin
         g_off  = off_q + LEN_WIDTH'(KEEP_WIDTH);
      end
   end

   always_comb begin
      g_last = ({1'b0, g_off} + LW1'(KEEP_WIDTH)) >= {1'b0, g_len};
      g_data = '0;
      g_keep = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         g_keep[i] = (KEEP_ENABLE == 0) || (({1'b0, g_off} + LW1'(i)) < {1'b0, g_len});
         g_data[i*8 +: 8] = g_keep[i] ? (g_seed + 8'(g_pkt) + 8'(g_off) + 8'(i)) : 8'h00;
      end
      g_user = g_err & g_last & (g_pkt == g_cnt - CNT_WIDTH'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (cfg_start)
                    state_d = (cfg_len == '0 || cfg_count == '0) ? S_FIN : S_SEND;
         S_SEND: if (hs && tlast_q) begin
                    if (last_pkt)          state_d = S_FIN;
                    else if (gap_q != '0)  state_d = S_GAP;
                 end
         S_GAP:  if (cfg_abort)                        state_d = S_FIN;
                 else if (gcnt_q == GAP_WIDTH'(1))     state_d = S_SEND;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_SEND) || (state_q == S_GAP);
      done = (state_q == S_FIN);
      load = (state_d == S_SEND) && ((state_q != S_SEND) || hs);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q <= '0; off_q <= '0; cnt_q <= '0; sent_q <= '0;
         gap_q <= '0; gcnt_q <= '0; seed_q <= '0; err_q <= 1'b0; abort_q <= 1'b0;
         tdata_q <= '0; tkeep_q <= '0; tvalid_q <= 1'b0; tlast_q <= 1'b0; tuser_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && cfg_start) begin
            len_q <= cfg_len; cnt_q <= cfg_count; gap_q <= cfg_gap;
            seed_q <= cfg_seed; err_q <= cfg_err_inj;
            sent_q <= '0; abort_q <= 1'b0;
         end
         if (state_q == S_SEND && cfg_abort) abort_q <= 1'b1;
         if (state_q == S_SEND && hs && tlast_q) sent_q <= sent_q + CNT_WIDTH'(1);
         if (state_q == S_SEND && state_d == S_GAP) gcnt_q <= gap_q;
         else if (state_q == S_GAP)                gcnt_q <= gcnt_q - GAP_WIDTH'(1);
         if (load) begin
            off_q <= g_off; tdata_q <= g_data; tkeep_q <= g_keep;
            tlast_q <= g_last; tuser_q <= g_user; tvalid_q <= 1'b1;
         end else if (hs) begin
            tdata_q <= '0; tkeep_q <= '0; tlast_q <= 1'b0; tuser_q <= 1'b0; tvalid_q <= 1'b0;
         end
      end
   end

   assign pkt_sent      = sent_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
endmodule
